// File: rtl/ttl_pkg.sv
// Shared constants and types for the cascaded TTL-style counter.
package ttl_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef logic [3:0] nibble_t;

  localparam nibble_t NIBBLE_TC_UP = 4'hF;
  localparam nibble_t NIBBLE_TC_DN = 4'h0;

  // Terminal nibble for the current count direction.
  function automatic nibble_t nibble_tc(input logic dir);
    return (dir == DIR_UP) ? NIBBLE_TC_UP : NIBBLE_TC_DN;
  endfunction

endpackage

// File: rtl/ttl_counter_stage.sv
// One 4-bit up/down counter stage (74LS161/163-like nibble).
// Priority: sclr, load, carry_in step, hold. tc flags the terminal nibble
// for the current direction without any enable gating.
module ttl_counter_stage
  import ttl_pkg::*;
(
  input  logic    clk,
  input  logic    n_clr,
  input  logic    carry_in,
  input  logic    dir,
  input  logic    load,
  input  logic    sclr,
  input  nibble_t din,
  output nibble_t q,
  output logic    tc
);

  nibble_t cnt_q;
  nibble_t cnt_d;

  // Next nibble value by clear/load/step priority.
  always_comb begin
    cnt_d = cnt_q;
    if (sclr) begin
      cnt_d = 4'h0;
    end else if (load) begin
      cnt_d = din;
    end else if (carry_in) begin
      cnt_d = (dir == DIR_UP) ? cnt_q + 4'd1 : cnt_q - 4'd1;
    end
  end

  // Nibble register with asynchronous clear.
  always_ff @(posedge clk or negedge n_clr) begin
    if (!n_clr) begin
      cnt_q <= 4'h0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q  = cnt_q;
  assign tc = (cnt_q == nibble_tc(dir));

endmodule

// File: rtl/ttl_counter_chain.sv
// N-nibble cascaded synchronous counter with up/down, sync clear,
// parallel load and optional reload of din on terminal count.
module ttl_counter_chain
  import ttl_pkg::*;
#(
  parameter int STAGES       = 2,
  parameter bit RELOAD_ON_TC = 1'b0
) (
  input  logic                  clk,
  input  logic                  n_clr,
  input  logic                  n_sclr,
  input  logic                  n_load,
  input  logic [4*STAGES-1:0]   din,
  input  logic                  enp,
  input  logic                  ent,
  input  logic                  dir,
  output logic [4*STAGES-1:0]   q,
  output logic                  rco,
  output logic [STAGES-1:0]     stage_rco,
  output logic                  tc_q
);

  logic [STAGES-1:0] stage_tc;
  logic [STAGES-1:0] carry_in;
  logic [STAGES-1:0] chain;
  logic              count_en;
  logic              step;
  logic              reload;
  logic              stage_load;
  logic              tc_d;

  assign count_en = enp & ent;
  assign step     = count_en & n_sclr & n_load;

  // Ripple the terminal-count chain. chain[] is the ent-gated cascade carry
  // (no enp path); each stage's count enable additionally needs enp so that
  // enp=0 freezes every stage, not just stage 0.
  always_comb begin
    logic acc;
    acc      = ent;
    chain    = '0;
    carry_in = '0;
    for (int i = 0; i < STAGES; i++) begin
      carry_in[i] = count_en & acc;
      acc         = acc & stage_tc[i];
      chain[i]    = acc;
    end
  end

  assign stage_rco  = chain;
  assign rco        = chain[STAGES-1];
  assign reload     = RELOAD_ON_TC & step & rco;
  assign stage_load = ~n_load | reload;
  assign tc_d       = step & rco;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    ttl_counter_stage u_stage (
      .clk      (clk),
      .n_clr    (n_clr),
      .carry_in (carry_in[g]),
      .dir      (dir),
      .load     (stage_load),
      .sclr     (~n_sclr),
      .din      (din[4*g +: 4]),
      .q        (q[4*g +: 4]),
      .tc       (stage_tc[g])
    );
  end

  // Wrap/reload pulse, one cycle after the terminal-count step.
  always_ff @(posedge clk or negedge n_clr) begin
    if (!n_clr) begin
      tc_q <= 1'b0;
    end else begin
      tc_q <= tc_d;
    end
  end

endmodule

// File: tb/tb_ttl_counter_chain.sv
// Bench for ttl_counter_chain: three instances (8-bit wrap, 8-bit reload,
// 16-bit wrap) share control inputs and are tracked by a whole-word model.
module tb_ttl_counter_chain;

  logic        clk;
  logic        n_clr, n_sclr, n_load, enp, ent, dir;
  logic [7:0]  din2;
  logic [15:0] din4;

  logic [7:0]  q2, qr;
  logic [15:0] q4;
  logic        rco2, rcor, rco4, tc2, tcr, tc4;
  logic [1:0]  srco2, srcor;
  logic [3:0]  srco4;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state (whole-word values)
  longint unsigned m2, mr, m4;
  bit              mt2, mtr, mt4;

  ttl_counter_chain #(.STAGES(2), .RELOAD_ON_TC(1'b0)) dut (
    .clk(clk), .n_clr(n_clr), .n_sclr(n_sclr), .n_load(n_load), .din(din2),
    .enp(enp), .ent(ent), .dir(dir), .q(q2), .rco(rco2), .stage_rco(srco2), .tc_q(tc2));

  ttl_counter_chain #(.STAGES(2), .RELOAD_ON_TC(1'b1)) dut_r (
    .clk(clk), .n_clr(n_clr), .n_sclr(n_sclr), .n_load(n_load), .din(din2),
    .enp(enp), .ent(ent), .dir(dir), .q(qr), .rco(rcor), .stage_rco(srcor), .tc_q(tcr));

  ttl_counter_chain #(.STAGES(4), .RELOAD_ON_TC(1'b0)) dut4 (
    .clk(clk), .n_clr(n_clr), .n_sclr(n_sclr), .n_load(n_load), .din(din4),
    .enp(enp), .ent(ent), .dir(dir), .q(q4), .rco(rco4), .stage_rco(srco4), .tc_q(tc4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural next state from the priority rules, whole-word arithmetic.
  function automatic void mstep(input longint unsigned q, input int w, input bit rl,
                                input longint unsigned d, output longint unsigned nq,
                                output bit ntc);
    longint unsigned modv, tcv;
    modv = longint'(1) << w;
    tcv  = dir ? modv - 1 : 0;
    nq   = q;
    ntc  = 1'b0;
    if (!n_clr || !n_sclr) begin
      nq = 0;
    end else if (!n_load) begin
      nq = d % modv;
    end else if (enp && ent) begin
      ntc = (q == tcv);
      if (ntc && rl) nq = d % modv;
      else           nq = dir ? (q + 1) % modv : (q + modv - 1) % modv;
    end
  endfunction

  function automatic bit exp_rco(input longint unsigned q, input int w);
    longint unsigned mask;
    mask = (longint'(1) << w) - 1;
    return ent && (q == (dir ? mask : 0));
  endfunction

  function automatic logic [3:0] exp_srco(input longint unsigned q, input int stages);
    logic [3:0] r;
    longint unsigned mask;
    r = '0;
    for (int i = 0; i < stages; i++) begin
      mask = (longint'(1) << (4 * (i + 1))) - 1;
      r[i] = ent && ((q & mask) == (dir ? mask : 0));
    end
    return r;
  endfunction

  // Advance one clock: compute model next state, take the edge, settle.
  task automatic tick();
    longint unsigned n2, nr, n4;
    bit t2, tr, t4;
    mstep(m2, 8, 1'b0, longint'(din2), n2, t2);
    mstep(mr, 8, 1'b1, longint'(din2), nr, tr);
    mstep(m4, 16, 1'b0, longint'(din4), n4, t4);
    @(posedge clk);
    #1;
    m2 = n2; mr = nr; m4 = n4;
    mt2 = t2; mtr = tr; mt4 = t4;
  endtask

  task automatic load_val(input logic [7:0] v2, input logic [15:0] v4);
    n_sclr = 1'b1; n_load = 1'b0; din2 = v2; din4 = v4;
    tick();
    n_load = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    n_clr = 1'b0; n_sclr = 1'b1; n_load = 1'b1; enp = 1'b0; ent = 1'b0; dir = 1'b1;
    din2 = 8'h00; din4 = 16'h0000;
    m2 = 0; mr = 0; m4 = 0; mt2 = 0; mtr = 0; mt4 = 0;
    #1;
    n_checks++; if (q2 !== 8'h00) begin n_fail++; $display("FAIL reset_q got=%h exp=00", q2); end
    n_checks++; if (tc2 !== 1'b0) begin n_fail++; $display("FAIL reset_tc_q got=%b exp=0", tc2); end
    repeat (2) tick();
    n_clr = 1'b1;
    load_val(8'h5A, 16'h5A5A);
    n_checks++; if (q2 !== 8'h5A) begin n_fail++; $display("FAIL reset_preload got=%h exp=5A", q2); end
    // Assert n_clr between edges: output must clear without a clock edge.
    #1;
    dir = 1'b0; ent = 1'b1;
    n_clr = 1'b0;
    #1;
    m2 = 0; mr = 0; m4 = 0; mt2 = 0; mtr = 0; mt4 = 0;
    n_checks++; if (q2 !== 8'h00) begin n_fail++; $display("FAIL async_clr_q got=%h exp=00", q2); end
    n_checks++; if (q4 !== 16'h0000) begin n_fail++; $display("FAIL async_clr_q4 got=%h exp=0000", q4); end
    n_checks++; if (tc2 !== 1'b0) begin n_fail++; $display("FAIL async_clr_tc got=%b exp=0", tc2); end
    n_checks++; if (rco2 !== 1'b1 || srco2 !== 2'b11) begin n_fail++;
      $display("FAIL async_clr_rco got=%b/%b exp=1/11", rco2, srco2); end
    n_clr = 1'b1; dir = 1'b1; enp = 1'b1;
    tick();
    n_checks++; if (q2 !== 8'h01) begin n_fail++; $display("FAIL reset_resume got=%h exp=01", q2); end
  endtask

  task automatic test_up_wrap();
    enp = 1'b0; ent = 1'b0; dir = 1'b1;
    load_val(8'hFE, 16'hFFFE);
    enp = 1'b1; ent = 1'b1;
    #1;
    n_checks++; if (q2 !== 8'hFE || rco2 !== 1'b0) begin n_fail++;
      $display("FAIL up_fe got=%h/%b exp=FE/0", q2, rco2); end
    tick();
    n_checks++; if (q2 !== 8'hFF || rco2 !== 1'b1 || srco2 !== 2'b11 || tc2 !== 1'b0) begin n_fail++;
      $display("FAIL up_ff got q=%h rco=%b srco=%b tc=%b exp FF/1/11/0", q2, rco2, srco2, tc2); end
    tick();
    n_checks++; if (q2 !== 8'h00 || tc2 !== 1'b1) begin n_fail++;
      $display("FAIL up_wrap got q=%h tc=%b exp 00/1", q2, tc2); end
    tick();
    n_checks++; if (q2 !== 8'h01 || tc2 !== 1'b0) begin n_fail++;
      $display("FAIL up_after got q=%h tc=%b exp 01/0", q2, tc2); end
  endtask

  task automatic test_reload();
    int cnt;
    enp = 1'b0; ent = 1'b0; dir = 1'b1;
    load_val(8'hFE, 16'h0000);
    din2 = 8'hC0; enp = 1'b1; ent = 1'b1;
    tick();
    n_checks++; if (qr !== 8'hFF) begin n_fail++; $display("FAIL reload_ff got=%h exp=FF", qr); end
    tick();
    n_checks++; if (qr !== 8'hC0 || tcr !== 1'b1) begin n_fail++;
      $display("FAIL reload_c0 got q=%h tc=%b exp C0/1", qr, tcr); end
    tick();
    n_checks++; if (qr !== 8'hC1 || tcr !== 1'b0) begin n_fail++;
      $display("FAIL reload_c1 got q=%h tc=%b exp C1/0", qr, tcr); end
    cnt = 1;
    while (tcr !== 1'b1 && cnt < 200) begin
      tick();
      cnt++;
    end
    n_checks++; if (cnt != 64 || qr !== 8'hC0) begin n_fail++;
      $display("FAIL reload_period got=%0d q=%h exp=64 q=C0", cnt, qr); end
  endtask

  task automatic test_down_wrap();
    enp = 1'b0; ent = 1'b0; dir = 1'b0;
    load_val(8'h01, 16'h0001);
    enp = 1'b1; ent = 1'b1;
    tick();
    n_checks++; if (q2 !== 8'h00 || rco2 !== 1'b1) begin n_fail++;
      $display("FAIL down_00 got q=%h rco=%b exp 00/1", q2, rco2); end
    tick();
    n_checks++; if (q2 !== 8'hFF || tc2 !== 1'b1) begin n_fail++;
      $display("FAIL down_wrap got q=%h tc=%b exp FF/1", q2, tc2); end
    enp = 1'b0;
    load_val(8'h0F, 16'h000F);
    dir = 1'b1;
    #1;
    n_checks++; if (rco2 !== 1'b0 || srco2[0] !== 1'b1) begin n_fail++;
      $display("FAIL dir_up_0f got rco=%b srco0=%b exp 0/1", rco2, srco2[0]); end
    dir = 1'b0;
    #1;
    n_checks++; if (rco2 !== 1'b0 || srco2[0] !== 1'b0) begin n_fail++;
      $display("FAIL dir_dn_0f got rco=%b srco0=%b exp 0/0", rco2, srco2[0]); end
  endtask

  task automatic test_priority();
    enp = 1'b0; ent = 1'b0; dir = 1'b1;
    load_val(8'h77, 16'h7777);
    n_sclr = 1'b0; n_load = 1'b0; din2 = 8'h33;
    tick();
    n_checks++; if (q2 !== 8'h00) begin n_fail++; $display("FAIL prio_clr got=%h exp=00", q2); end
    n_sclr = 1'b1;
    load_val(8'hFF, 16'hFFFF);
    n_load = 1'b0; din2 = 8'h33; enp = 1'b1; ent = 1'b1;
    tick();
    n_load = 1'b1;
    n_checks++; if (q2 !== 8'h33 || tc2 !== 1'b0) begin n_fail++;
      $display("FAIL prio_load_tc got q=%h tc=%b exp 33/0", q2, tc2); end
  endtask

  task automatic test_enables();
    enp = 1'b0; ent = 1'b0; dir = 1'b1;
    load_val(8'hFF, 16'hFFFF);
    enp = 1'b1; ent = 1'b0;
    tick();
    n_checks++; if (q2 !== 8'hFF || rco2 !== 1'b0) begin n_fail++;
      $display("FAIL ent_low got q=%h rco=%b exp FF/0", q2, rco2); end
    n_checks++; if (q4 !== 16'hFFFF || rco4 !== 1'b0) begin n_fail++;
      $display("FAIL ent_low4 got q=%h rco=%b exp FFFF/0", q4, rco4); end
    enp = 1'b0; ent = 1'b1;
    tick();
    n_checks++; if (q2 !== 8'hFF || rco2 !== 1'b1 || tc2 !== 1'b0) begin n_fail++;
      $display("FAIL enp_low got q=%h rco=%b tc=%b exp FF/1/0", q2, rco2, tc2); end
    n_checks++; if (q4 !== 16'hFFFF || rco4 !== 1'b1 || srco4 !== 4'hF || tc4 !== 1'b0) begin n_fail++;
      $display("FAIL enp_low4 got q=%h rco=%b srco=%h tc=%b exp FFFF/1/F/0", q4, rco4, srco4, tc4); end
    load_val(8'h0F, 16'h0FFF);
    tick();
    n_checks++; if (q2 !== 8'h0F || q4 !== 16'h0FFF) begin n_fail++;
      $display("FAIL enp_low_cascade got q=%h q4=%h exp 0F/0FFF", q2, q4); end
    load_val(8'hFF, 16'hFFFF);
    enp = 1'b1;
    tick();
    n_checks++; if (q4 !== 16'h0000 || tc4 !== 1'b1) begin n_fail++;
      $display("FAIL wrap4 got q=%h tc=%b exp 0000/1", q4, tc4); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      n_clr  = ($urandom_range(0, 59) != 0);
      n_sclr = ($urandom_range(0, 29) != 0);
      n_load = ($urandom_range(0, 11) != 0);
      enp    = ($urandom_range(0, 7) != 0);
      ent    = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      din2   = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(240, 255)) : 8'($urandom_range(0, 15));
      din4   = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(65520, 65535)) : 16'($urandom_range(0, 15));
      #1;
      if (!n_clr) begin
        m2 = 0; mr = 0; m4 = 0; mt2 = 0; mtr = 0; mt4 = 0;
      end
      n_checks++; if (longint'(q2) != m2 || tc2 !== mt2) begin n_fail++;
        $display("FAIL rnd_q2 cyc=%0d got=%h/%b exp=%h/%b", i, q2, tc2, m2, mt2); end
      n_checks++; if (longint'(qr) != mr || tcr !== mtr) begin n_fail++;
        $display("FAIL rnd_qr cyc=%0d got=%h/%b exp=%h/%b", i, qr, tcr, mr, mtr); end
      n_checks++; if (longint'(q4) != m4 || tc4 !== mt4) begin n_fail++;
        $display("FAIL rnd_q4 cyc=%0d got=%h/%b exp=%h/%b", i, q4, tc4, m4, mt4); end
      n_checks++; if (rco2 !== exp_rco(m2, 8) || srco2 !== exp_srco(m2, 2)) begin n_fail++;
        $display("FAIL rnd_rco2 cyc=%0d got=%b/%b", i, rco2, srco2); end
      n_checks++; if (rcor !== exp_rco(mr, 8) || srcor !== exp_srco(mr, 2)) begin n_fail++;
        $display("FAIL rnd_rcor cyc=%0d got=%b/%b", i, rcor, srcor); end
      n_checks++; if (rco4 !== exp_rco(m4, 16) || srco4 !== exp_srco(m4, 4)) begin n_fail++;
        $display("FAIL rnd_rco4 cyc=%0d got=%b/%h", i, rco4, srco4); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_reload();
    test_down_wrap();
    test_priority();
    test_enables();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
